div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider in the EX stage (DIV/DIVU). Source of stallreq_for_ex
//  into the pipeline controller: requests a freeze of IF..EX while a division is in flight.
//  Writes HI (remainder) and LO (quotient) via result_o once ready_o is asserted.
// PARAMETERS
//  DATA_W   32   operand width; result_o is 2*DATA_W
//  CNT_W    6    iteration counter width; must satisfy 2^CNT_W > DATA_W
// PORTS
//  clk              in   1         pipeline clock, rising edge
//  rst              in   1         asynchronous reset, active-low
//  start_i          in   1         EX holds high while a DIV/DIVU occupies EX
//  signed_i         in   1         1 = DIV (two's complement), 0 = DIVU
//  annul_i          in   1         abort current division (flush), any state
//  opdata1_i        in   DATA_W    dividend; sampled in IDLE when start_i=1
//  opdata2_i        in   DATA_W    divisor; sampled in IDLE when start_i=1
//  result_o         out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1
//  ready_o          out  1         result valid (END state)
//  stallreq_for_ex  out  1         stall request to pipeline controller
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, result_o=0, ready_o=0, all regs 0.
//  - States: IDLE, BY_ZERO, ON, END. Operands latched at start; later input changes ignored.
//  - IDLE: start_i=1 & ~annul_i at edge T -> divisor==0 ? BY_ZERO : ON (at T+1).
//  - BY_ZERO: one cycle, then END. Result forced to 64'h0.
//  - ON: signed mode divides |op1| by |op2|; one quotient bit per cycle (shift dividend
//    into partial remainder, subtract divisor if no borrow, shift in 1 else 0);
//    counter 0..DATA_W-1; after DATA_W cycles -> END. Normal path: END at T+DATA_W+1.
//  - Sign fix on entering END (signed_i=1 only): quotient negated if op signs differ,
//    remainder takes dividend sign. 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, rem 0.
//  - END: ready_o=1, result_o stable. Stays in END while start_i=1; start_i=0 -> IDLE,
//    ready_o=0, result_o cleared to 0 next cycle. No back-to-back restart from END.
//  - stallreq_for_ex (combinational) = (IDLE & start_i & ~annul_i) | BY_ZERO | ON.
//    Deasserted in END so the stage advances exactly once with the result.
//  - annul_i=1: from any state -> IDLE next edge, ready_o=0; annul wins over start_i.
//  - Reset mid-division: immediate return to IDLE, partial result discarded.
// CONFIGURATION
//  DIV_EARLY_EXIT_EN defined: in IDLE with start, if |op1| < |op2| (unsigned compare of
//   magnitudes), go directly to END at T+1 with quotient=0, remainder=op1 (original sign);
//   stallreq_for_ex high for only the start cycle. Divisor==0 check takes priority.
//  DIV_EARLY_EXIT_EN undefined: all nonzero divisors take the full DATA_W-cycle ON path.
// TESTING
//  1. DIVU 100/7, start held -> stall high T..T+32, ready_o at T+33, result_o={32'd2,32'd14}.
//  2. DIV -100/7 -> quotient 0xFFFF_FFF2 (-14), remainder 0xFFFF_FFFE (-2); 7/-2 -> -3, rem 1.
//  3. DIV 0x8000_0000/0xFFFF_FFFF -> result_o={32'h0,32'h8000_0000}, no hang.
//  4. Divisor 0 -> BY_ZERO at T+1, END at T+2, result_o=64'h0, stall low in END.
//  5. annul_i pulse at ON counter=10 -> IDLE next cycle, ready_o stays 0, stall drops;
//     rst low mid-ON -> all outputs 0 immediately; new start then completes correctly.
//  6. DIV_EARLY_EXIT_EN on: DIVU 3/9 -> END at T+1, result_o={32'd3,32'd0}; off: END at T+33.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (DIV/DIVU) that raises a pipeline stall while busy.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module div_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_for_ex
);
    localparam int unsigned RES_W = 2 * DATA_W;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_BY_ZERO = 2'b01;
    localparam logic [1:0] S_ON      = 2'b10;
    localparam logic [1:0] S_END     = 2'b11;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dvd_q;      // dividend magnitude, becomes quotient as bits shift in
    logic [DATA_W-1:0] dsr_q;
    logic [DATA_W-1:0] rem_q;
    logic              neg_quo_q, neg_rem_q;

    // Operand magnitudes for signed mode
    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_mag, op2_mag;
    logic              div_zero, early_exit;

    assign op1_neg  = signed_i & opdata1_i[DATA_W-1];
    assign op2_neg  = signed_i & opdata2_i[DATA_W-1];
    assign op1_mag  = op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign op2_mag  = op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
    assign div_zero = (opdata2_i == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (op1_mag < op2_mag);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [DATA_W:0]   rem_sh, diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_nx, quo_nx, rem_fix, quo_fix;

    assign rem_sh  = {rem_q, dvd_q[DATA_W-1]};
    assign diff    = rem_sh - {1'b0, dsr_q};
    assign q_bit   = ~diff[DATA_W];
    assign rem_nx  = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quo_nx  = {dvd_q[DATA_W-2:0], q_bit};
    assign quo_fix = neg_quo_q ? (~quo_nx + DATA_W'(1)) : quo_nx;
    assign rem_fix = neg_rem_q ? (~rem_nx + DATA_W'(1)) : rem_nx;

    assign stallreq_for_ex = ((state_q == S_IDLE) & start_i & ~annul_i)
                           | (state_q == S_BY_ZERO)
                           | (state_q == S_ON);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (div_zero)        state_d = S_BY_ZERO;
                        else if (early_exit) state_d = S_END;
                        else                 state_d = S_ON;
                    end
                end
                S_BY_ZERO: state_d = S_END;
                S_ON:      if (cnt_q == LAST_CNT) state_d = S_END;
                S_END:     if (!start_i) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else if (annul_i) begin
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cnt_q     <= '0;
                        dvd_q     <= op1_mag;
                        dsr_q     <= op2_mag;
                        rem_q     <= '0;
                        neg_quo_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                        if (!div_zero && early_exit) begin
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                S_BY_ZERO: begin
                    result_o <= RES_W'(0);
                    ready_o  <= 1'b1;
                end
                S_ON: begin
                    dvd_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        cnt_q    <= '0;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ready_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table vectors, randomized checks against an arithmetic reference, and
// hand-written annul/reset sequences for div_iter.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_for_ex;

    int checks   = 0;
    int failures = 0;

    div_iter #(.DATA_W(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .signed_i        (signed_i),
        .annul_i         (annul_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .result_o        (result_o),
        .ready_o         (ready_o),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; remainder takes dividend sign
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Expected number of cycles from the start edge until ready_o is seen
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint x, y;
        if (b == 32'd0) return 2;
        x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (x < 0) x = -x;
        if (y < 0) y = -y;
`ifdef DIV_EARLY_EXIT_EN
        if (x < y) return 1;
`endif
        return 33;
    endfunction

    task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int lat);
        int n;
        bit seen;
        bit stall_bad;
        logic [63:0] held;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        check({nm, "_stall_start"}, 64'(stallreq_for_ex), 64'd1);
        n = 0; seen = 0; stall_bad = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                opdata1_i = ~a;
                opdata2_i = b ^ 32'h5;
            end
            #1;
            if (ready_o) seen = 1;
            else if (!stallreq_for_ex) stall_bad = 1;
        end
        check({nm, "_latency"}, 64'(n), 64'(lat));
        check({nm, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check({nm, "_result"}, result_o, exp);
        check({nm, "_stall_end"}, 64'(stallreq_for_ex), 64'd0);
        held = result_o;
        @(posedge clk);
        @(negedge clk);
        #1;
        check({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({nm, "_hold_result"}, result_o, held);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check({nm, "_clr_ready"}, 64'(ready_o), 64'd0);
        check({nm, "_clr_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        int          sel;
        bit          seen;
        int          n;

        tbl[0] = '{32'd100,        32'd7,          1'b0, {32'd2,        32'd14}};
        tbl[1] = '{32'hFFFF_FF9C,  32'd7,          1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}};
        tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1,        32'hFFFF_FFFD}};
        tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0,        32'h8000_0000}};
        tbl[4] = '{32'd5,          32'd0,          1'b0, 64'h0};
        tbl[5] = '{32'd3,          32'd9,          1'b0, {32'd3,        32'd0}};
        tbl[6] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0,        32'hFFFF_FFFF}};
        tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0}};
        tbl[8] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};

        rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stallreq_for_ex), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++)
            run_div($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].exp,
                    ref_lat(tbl[i].a, tbl[i].b, tbl[i].sgn));

        // Randomized operands, biased toward zero/small/extreme divisors
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else if (sel == 5) b = a + 32'($urandom_range(1, 3));
            else               b = $urandom;
            sgn = 1'($urandom_range(0, 1));
            run_div($sformatf("rnd%0d", i), a, b, sgn, ref_div(a, b, sgn), ref_lat(a, b, sgn));
        end

        // Annul in IDLE wins over start
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd3; signed_i = 1'b0;
        #1;
        check("annul_idle_stall", 64'(stallreq_for_ex), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        #1;
        check("annul_idle_nostart", 64'(stallreq_for_ex), 64'd0);

        // Annul while ON at counter 10
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (11) @(posedge clk);
        @(negedge clk);
        #1;
        check("annul_on_busy", 64'(stallreq_for_ex), 64'd1);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        check("annul_on_stall", 64'(stallreq_for_ex), 64'd0);
        check("annul_on_ready", 64'(ready_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1;
        end
        check("annul_on_never_ready", 64'(seen), 64'd0);
        run_div("after_annul", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33);

        // Annul in END with start held
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
        end
        check("annul_end_reached", 64'(ready_o), 64'd1);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("annul_end_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // Async reset mid-ON
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd5;
        repeat (6) @(posedge clk);
        #2;
        start_i = 1'b0; rst = 1'b0;
        #1;
        check("rst_on_stall", 64'(stallreq_for_ex), 64'd0);
        check("rst_on_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Async reset while in END clears the result immediately
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
        end
        check("rst_end_result_pre", result_o, {32'd2, 32'd14});
        #1;
        start_i = 1'b0; rst = 1'b0;
        #1;
        check("rst_end_result", result_o, 64'd0);
        check("rst_end_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
